csr_write_queue: RTL

- Buffers speculative CSR writes produced by the control ALU and releases them to the CSR file in program order, only after the owning active-list entry commits.
- Sits between the control-ALU execute stage and the CSR file.
- Discards uncommitted writes on a pipeline flush.
- Forwards the youngest pending value to CSR reads so that execute reads stay coherent.

---
 rtl/csr_write_queue.sv | 103 ++++++++++
 1 files changed

// File: rtl/csr_write_queue.sv
// csr_write_queue: holds speculative CSR writes until commit, drains them in order, forwards pending values to reads.
module csr_write_queue #(
  parameter int DEPTH  = 4,
  parameter int CSR_W  = 64,
  parameter int ADDR_W = 12,
  parameter int TAG_W  = 7,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid_i,
  input  logic [ADDR_W-1:0] enq_addr_i,
  input  logic [CSR_W-1:0]  enq_data_i,
  input  logic [TAG_W-1:0]  enq_tag_i,
  output logic              enq_ready_o,
  input  logic              commit_valid_i,
  input  logic [TAG_W-1:0]  commit_tag_i,
  input  logic              flush_i,
  input  logic              csr_busy_i,
  output logic              csr_wr_en_o,
  output logic [ADDR_W-1:0] csr_wr_addr_o,
  output logic [CSR_W-1:0]  csr_wr_data_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_hit_o,
  output logic [CSR_W-1:0]  rd_data_o,
  output logic [PW:0]       count_o,
  output logic              empty_o
);
  logic [PW:0]       head, cptr, tail, cptr_n, tail_n;
  logic [DEPTH-1:0]  vld, cmt, vld_n, cmt_n;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [CSR_W-1:0]  data_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [PW-1:0]     hidx, cidx, tidx, idx;
  logic              do_enq, do_commit;
  always_comb begin
    hidx          = head[PW-1:0];
    cidx          = cptr[PW-1:0];
    tidx          = tail[PW-1:0];
    count_o       = tail - head;
    empty_o       = count_o == '0;
    enq_ready_o   = !count_o[PW];
    do_enq        = enq_valid_i && enq_ready_o && !flush_i;
    do_commit     = commit_valid_i && vld[cidx] && !cmt[cidx] && tag_q[cidx] == commit_tag_i;
    csr_wr_en_o   = vld[hidx] && cmt[hidx] && !csr_busy_i;
    csr_wr_addr_o = csr_wr_en_o ? addr_q[hidx] : '0;
    csr_wr_data_o = csr_wr_en_o ? data_q[hidx] : '0;
    cptr_n        = cptr + (PW+1)'(do_commit);
    tail_n        = flush_i ? cptr_n : tail + (PW+1)'(do_enq);
  end
  // Flush keeps only committed entries, including one committing this same cycle.
  always_comb begin
    vld_n = flush_i ? vld & cmt : vld;
    cmt_n = cmt;
    if (do_commit) begin
      vld_n[cidx] = 1'b1;
      cmt_n[cidx] = 1'b1;
    end
    if (csr_wr_en_o) begin
      vld_n[hidx] = 1'b0;
      cmt_n[hidx] = 1'b0;
    end
    if (do_enq) begin
      vld_n[tidx] = 1'b1;
      cmt_n[tidx] = 1'b0;
    end
  end
  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    rd_hit_o  = 1'b0;
    rd_data_o = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = hidx + PW'(k);
      if (vld[idx] && addr_q[idx] == rd_addr_i) begin
        rd_hit_o  = 1'b1;
        rd_data_o = data_q[idx];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      cptr <= '0;
      tail <= '0;
      vld  <= '0;
      cmt  <= '0;
    end else begin
      head <= head + (PW+1)'(csr_wr_en_o);
      cptr <= cptr_n;
      tail <= tail_n;
      vld  <= vld_n;
      cmt  <= cmt_n;
    end
  end
  always_ff @(posedge clk) begin
    if (do_enq) begin
      addr_q[tidx] <= enq_addr_i;
      data_q[tidx] <= enq_data_i;
      tag_q[tidx]  <= enq_tag_i;
    end
  end
endmodule
